// File: rtl/spectrum_packet_buffer.sv
// spectrum_packet_buffer: framed spectrum packet store-and-forward buffer.
// Ports: master_clock, reset (async, active-high); s_data_* input stream
//   (never stalled); m_data_* output stream of committed packets only;
//   pkt_good_count / pkt_drop_count (saturating); fill_level (committed,
//   not yet read words).
module spectrum_packet_buffer #(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned PAYLOAD_WORDS = 512,
  parameter logic [31:0] HEADER_VALUE  = 32'hAAAAAAAA,
  parameter logic [31:0] FOOTER_VALUE  = 32'h55555555
) (
  input  logic                  master_clock,
  input  logic                  reset,
  input  logic [31:0]           s_data_tdata,
  input  logic                  s_data_tvalid,
  input  logic                  s_data_tlast,
  output logic                  s_data_tready,
  output logic [31:0]           m_data_tdata,
  output logic                  m_data_tvalid,
  output logic                  m_data_tlast,
  input  logic                  m_data_tready,
  output logic [15:0]           pkt_good_count,
  output logic [15:0]           pkt_drop_count,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = $clog2(PAYLOAD_WORDS + 1);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t          FULL_DIST = ptr_t'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {
    HUNT,
    STAMP,
    PAYLOAD,
    FOOTER,
    DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            commit_ptr_q, commit_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic            commit_pend_q, commit_pend_d;
  logic [15:0]     good_q, good_d;
  logic [15:0]     drop_q, drop_d;
  logic            m_valid_q, m_valid_d;
  logic [32:0]     m_word_q, m_word_d;

  // bit 32 is the stored tlast flag (set only on footers)
  logic [32:0]     mem_q [DEPTH];

  logic            acc;
  logic            full;
  logic            we;
  logic            wlast;
  logic            bad;
  logic            ovf;
  logic            drop;
  logic            avail;
  logic            load;
  ptr_t            cons;
  ptr_t            base;

  assign acc = s_data_tvalid & ~reset;

  // The word parked in the output register is still unread, so the
  // consumed position trails the fetch pointer by one while it is valid.
  assign cons = rd_ptr_q - ptr_t'(m_valid_q);
  assign full = (wr_ptr_q - cons) == FULL_DIST;

  // A packet whose footer was written last cycle is not yet reflected in
  // commit_ptr_q; a rewind in that cycle must not throw it away.
  assign base = commit_pend_q ? wr_ptr_q : commit_ptr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    commit_pend_d = 1'b0;
    we            = 1'b0;
    wlast         = 1'b0;
    bad           = 1'b0;
    ovf           = 1'b0;
    if (acc) begin
      unique case (state_q)
        HUNT: begin
          if (s_data_tdata == HEADER_VALUE) begin
            if (full) begin
              ovf = 1'b1;
            end else begin
              we      = 1'b1;
              state_d = STAMP;
            end
          end
        end
        STAMP: begin
          if (s_data_tlast) begin
            bad = 1'b1;
          end else if (full) begin
            ovf = 1'b1;
          end else begin
            we      = 1'b1;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_data_tlast) begin
            bad = 1'b1;
          end else if (full) begin
            ovf = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_d = FOOTER;
            end
          end
        end
        FOOTER: begin
          if (!(s_data_tlast && s_data_tdata == FOOTER_VALUE)) begin
            bad = 1'b1;
          end else if (full) begin
            ovf = 1'b1;
          end else begin
            we            = 1'b1;
            wlast         = 1'b1;
            commit_pend_d = 1'b1;
            state_d       = HUNT;
          end
        end
        DISCARD: begin
          if (s_data_tlast) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (bad || ovf) begin
      wr_ptr_d = base;
      // an overflow on the packet's own last word needs no discard phase
      state_d  = (ovf && !s_data_tlast) ? DISCARD : HUNT;
    end else if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  assign drop = bad | ovf;

  always_comb begin
    commit_ptr_d = commit_ptr_q;
    good_d       = good_q;
    drop_d       = drop_q;
    if (commit_pend_q) begin
      commit_ptr_d = wr_ptr_q;
      if (good_q != 16'hFFFF) begin
        good_d = good_q + 16'd1;
      end
    end
    if (drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  assign avail = commit_ptr_q != rd_ptr_q;
  assign load  = avail & (~m_valid_q | m_data_tready);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_word_d  = m_word_q;
    if (load) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      m_valid_d = 1'b1;
      m_word_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end else if (m_data_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge master_clock) begin
    if (we) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {wlast, s_data_tdata};
    end
  end

  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      commit_pend_q <= 1'b0;
      good_q        <= '0;
      drop_q        <= '0;
      m_valid_q     <= 1'b0;
      m_word_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_pend_q <= commit_pend_d;
      good_q        <= good_d;
      drop_q        <= drop_d;
      m_valid_q     <= m_valid_d;
      m_word_q      <= m_word_d;
    end
  end

  assign s_data_tready  = ~reset;
  assign m_data_tvalid  = m_valid_q;
  assign m_data_tdata   = m_word_q[31:0];
  assign m_data_tlast   = m_word_q[32];
  assign pkt_good_count = good_q;
  assign pkt_drop_count = drop_q;
  assign fill_level     = commit_ptr_q - cons;

endmodule

// File: tb/tb_spectrum_packet_buffer.sv
// Bench for spectrum_packet_buffer: table vectors, corner sequences,
// and a randomized run against a packet-level reference model.
module tb_spectrum_packet_buffer;

  localparam int AW = 4;
  localparam int PW = 4;
  localparam int PLEN = PW + 3;
  localparam logic [31:0] HDR = 32'hAAAAAAAA;
  localparam logic [31:0] FTR = 32'h55555555;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_data;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic [15:0]   good;
  logic [15:0]   drop;
  logic [AW:0]   fill;

  spectrum_packet_buffer #(
    .ADDR_WIDTH(AW),
    .PAYLOAD_WORDS(PW)
  ) dut (
    .master_clock(clk),
    .reset(rst),
    .s_data_tdata(s_data),
    .s_data_tvalid(s_valid),
    .s_data_tlast(s_last),
    .s_data_tready(s_ready),
    .m_data_tdata(m_data),
    .m_data_tvalid(m_valid),
    .m_data_tlast(m_last),
    .m_data_tready(m_ready),
    .pkt_good_count(good),
    .pkt_drop_count(drop),
    .fill_level(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        emit;
    int          good;
    int          drop;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] cur[$];
  int          m_good = 0;
  int          m_drop = 0;
  int          rx = 0;
  int          rx_last = 0;
  bit          rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid && m_ready) begin
      rx++;
      if (m_last) rx_last++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_word actual=%0h required=none", {m_last, m_data});
      end else begin
        chk("out_word", {m_last, m_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] stamp, input logic [31:0] b,
                          input bit push);
    logic [31:0] w;
    for (int k = 0; k < PLEN; k++) begin
      w = (k == 0) ? HDR : (k == 1) ? stamp :
          (k == PLEN - 1) ? FTR : b + 32'(k - 1);
      if (push) exp_q.push_back({k == PLEN - 1, w});
      send(w, k == PLEN - 1);
    end
  endtask

  // Packet-level reference: a packet is kept only if it is header,
  // stamp, PW words without tlast, then footer with tlast.
  function automatic void model(input logic [31:0] d, input logic l);
    int n;
    n = cur.size();
    if (n == 0) begin
      if (d == HDR) cur.push_back({1'b0, d});
    end else if (n <= PW + 1) begin
      if (l) begin
        m_drop++;
        cur.delete();
      end else begin
        cur.push_back({1'b0, d});
      end
    end else begin
      if (d == FTR && l) begin
        cur.push_back({1'b1, d});
        foreach (cur[i]) exp_q.push_back(cur[i]);
        m_good++;
      end else begin
        m_drop++;
      end
      cur.delete();
    end
  endfunction

  task automatic rsend(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (exp_q.size() + cur.size() >= 12) begin
      tick();
      n++;
      if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL stall_timeout actual=%0d required<12", exp_q.size());
        break;
      end
    end
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    model(d, l);
    send(d, l);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    exp_q.delete();
    cur.delete();
    m_good = 0;
    m_drop = 0;
    #1;
    chk("rst_stream", {s_ready, m_valid, m_last, m_data}, 64'h0);
    chk("rst_status", {good, drop, fill}, 64'h0);
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("post_rst", {m_valid, good, drop, fill}, 64'h0);
  endtask

  task automatic add(input logic [31:0] d, input logic l, input logic e,
                     input int g, input int dr);
    vec_t v;
    v.d = d;
    v.l = l;
    v.emit = e;
    v.good = g;
    v.drop = dr;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int rx0;
    int rl0;
    int kind;
    int bad_at;
    logic [31:0] d;
    logic l;

    s_data = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("init_stream", {s_ready, m_valid, m_last, m_data}, 64'h0);
    chk("init_status", {good, drop, fill}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    chk("ready_high", s_ready, 1);

    add(HDR, 0, 1, 0, 0);
    add(32'h10, 0, 1, 0, 0);
    add(32'h1, 0, 1, 0, 0);
    add(32'h2, 0, 1, 0, 0);
    add(32'h3, 0, 1, 0, 0);
    add(32'h4, 0, 1, 0, 0);
    add(FTR, 1, 1, 1, 0);
    add(HDR, 0, 0, 1, 0);
    add(32'h10, 0, 0, 1, 0);
    add(32'h1, 0, 0, 1, 0);
    add(32'h2, 0, 0, 1, 0);
    add(32'h3, 0, 0, 1, 0);
    add(32'h4, 0, 0, 1, 0);
    add(32'h55555554, 1, 0, 1, 1);
    add(HDR, 0, 0, 1, 1);
    add(32'h10, 0, 0, 1, 1);
    add(32'h1, 0, 0, 1, 1);
    add(32'h2, 1, 0, 1, 2);
    add(32'h12345678, 0, 0, 1, 2);
    add(32'h0000FFFF, 1, 0, 1, 2);
    add(HDR, 0, 1, 1, 2);
    add(32'h20, 0, 1, 1, 2);
    add(32'h5, 0, 1, 1, 2);
    add(32'h6, 0, 1, 1, 2);
    add(32'h7, 0, 1, 1, 2);
    add(32'h8, 0, 1, 1, 2);
    add(FTR, 1, 1, 2, 2);

    foreach (tbl[i]) begin
      if (tbl[i].emit) exp_q.push_back({tbl[i].l, tbl[i].d});
      send(tbl[i].d, tbl[i].l);
      idle(2);
      chk($sformatf("tbl%0d_good", i), good, tbl[i].good);
      chk($sformatf("tbl%0d_drop", i), drop, tbl[i].drop);
    end
    idle(20);
    chk("tbl_fill", fill, 0);
    chk("tbl_pending", exp_q.size(), 0);
    chk("tbl_lasts", rx_last, 2);

    // overflow: three packets into a 16-word buffer with no reader
    do_reset();
    m_ready = 1'b0;
    send_pkt(32'h100, 32'h1000, 1);
    send_pkt(32'h200, 32'h2000, 1);
    send_pkt(32'h300, 32'h3000, 0);
    idle(4);
    chk("ovf_good", good, 2);
    chk("ovf_drop", drop, 1);
    chk("ovf_fill", fill, 14);
    chk("ovf_hold0", {m_valid, m_last, m_data}, {2'b10, HDR});
    idle(3);
    chk("ovf_hold1", {m_valid, m_last, m_data}, {2'b10, HDR});
    rx0 = rx;
    rl0 = rx_last;
    m_ready = 1'b1;
    idle(25);
    chk("ovf_words", rx - rx0, 14);
    chk("ovf_lasts", rx_last - rl0, 2);
    chk("ovf_fill_end", fill, 0);

    // junk before a packet, then reset while it streams out
    do_reset();
    m_ready = 1'b1;
    send(32'h12345678, 1'b0);
    send(32'h0000FFFF, 1'b0);
    rx0 = rx;
    send_pkt(32'h10, 32'h40, 1);
    n = 0;
    while (!m_valid && n < 3) begin
      tick();
      n++;
    end
    chk("commit_latency", m_valid, 1);
    chk("junk_drop", drop, 0);
    chk("junk_good", good, 1);
    n = 0;
    while (rx - rx0 < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_output", rx - rx0 >= 3, 1);
    do_reset();
    rx0 = rx;
    idle(10);
    chk("no_stale", rx - rx0, 0);

    // randomized traffic against the packet model
    do_reset();
    rnd_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      bad_at = $urandom_range(1, PW + 1);
      if (kind == 0) begin
        d = $urandom;
        if (d == HDR) d = ~d;
        rsend(d, 1'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < PLEN; k++) begin
          d = (k == 0) ? HDR : (k == PLEN - 1) ? FTR : $urandom;
          l = (k == PLEN - 1);
          if (kind == 1 && k == bad_at) l = 1'b1;
          if (kind == 2 && k == PLEN - 1) begin
            if ($urandom_range(0, 1) == 1) d = FTR ^ (32'h1 << $urandom_range(0, 31));
            else l = 1'b0;
          end
          rsend(d, l);
          if (kind == 1 && k == bad_at) break;
        end
      end
    end
    rnd_rdy = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    idle(3);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_good", good, m_good);
    chk("rnd_drop", drop, m_drop);
    chk("rnd_fill", fill, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spectrum_packet_buffer.md
SPECTRUM_PACKET_BUFFER -- requirements
Module: spectrum_packet_buffer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning buffer depth is 2**ADDR_WIDTH words of 32 bits.
REQ-002 SHALL have parameter PAYLOAD_WORDS, default 512, meaning the exact number of payload words between the time stamp and the footer.
REQ-003 SHALL have parameter HEADER_VALUE, default 32'hAAAAAAAA, meaning the packet start marker.
REQ-004 SHALL have parameter FOOTER_VALUE, default 32'h55555555, meaning the packet end marker.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: master_clock  in  1  sole clock, 40 MHz; reset  in  1  asynchronous, active-high.
REQ-006 SHALL have these input-stream ports: s_data_tdata  in  32  packet word; s_data_tvalid  in  1  word valid; s_data_tlast  in  1  last word of packet; s_data_tready  out  1  accept.
REQ-007 SHALL have these output-stream ports: m_data_tdata  out  32  word; m_data_tvalid  out  1  valid; m_data_tlast  out  1  footer word; m_data_tready  in  1  downstream accept.
REQ-008 SHALL have these status ports: pkt_good_count  out  16  committed packets; pkt_drop_count  out  16  discarded packets; fill_level  out  ADDR_WIDTH+1  committed words not yet read.

Function
REQ-009 SHALL hold s_data_tready at 1 whenever reset is low, because the upstream has no backpressure; a word is accepted when s_data_tvalid=1 and s_data_tready=1.
REQ-010 SHALL run the input FSM HUNT -> STAMP -> PAYLOAD -> FOOTER -> HUNT, plus DISCARD, with one transition per accepted word.
REQ-011 In HUNT, SHALL write a word equal to HEADER_VALUE and go to STAMP, and SHALL silently drop any other word without counting it.
REQ-012 In STAMP, SHALL write the word and go to PAYLOAD with the payload counter cleared.
REQ-013 In PAYLOAD, SHALL write each word and increment the counter, and SHALL go to FOOTER after the PAYLOAD_WORDS-th word.
REQ-014 In FOOTER, SHALL store the word with its tlast flag set and commit the packet, but only when the word equals FOOTER_VALUE and s_data_tlast=1.
REQ-015 SHALL treat the packet as bad on s_data_tlast=1 in STAMP or PAYLOAD, or on a FOOTER word that mismatches or lacks tlast; a bad packet SHALL rewind the write pointer to the commit pointer, increment pkt_drop_count, and return to HUNT.
REQ-016 SHALL treat a write into a full buffer (write minus read pointer = 2**ADDR_WIDTH) as an overflow: the write pointer SHALL rewind, pkt_drop_count SHALL increment once, the FSM SHALL enter DISCARD, and no committed word SHALL ever be overwritten.
REQ-017 In DISCARD, SHALL drop words until one with s_data_tlast=1 is accepted, then return to HUNT.
REQ-018 SHALL advance the commit pointer, increment pkt_good_count, and update fill_level in the cycle after the footer write.
REQ-019 SHALL saturate both counters at 16'hFFFF.
REQ-020 SHALL make only committed words visible on the output; m_data_tvalid SHALL rise within 3 cycles of commit.
REQ-021 SHALL hold m_data_tdata and m_data_tlast stable while m_data_tvalid=1 and m_data_tready=0.
REQ-022 SHALL sustain one word per cycle while m_data_tready=1.
REQ-023 SHALL assert m_data_tlast only on stored footer words.
REQ-024 SHALL allow a commit and a read in the same cycle, with fill_level equal to the previous value plus the committed words minus 1.
REQ-025 SHALL wrap all pointers modulo 2**ADDR_WIDTH, with one extra bit used for full/empty detection.
REQ-026 SHALL handle a rewind and an output read in the same cycle without corrupting the read pointer.

Reset
REQ-027 While reset=1, SHALL drive all outputs to 0 (including s_data_tready), clear all pointers and counters, and put the FSM in HUNT, independent of the clock.
REQ-028 Reset mid-packet or mid-output SHALL discard all buffered data; after release no stale word SHALL appear.

Verification (bench parameters: ADDR_WIDTH=4, PAYLOAD_WORDS=4, so a packet is 7 words)
REQ-029 Good packet: send AAAAAAAA, 00000010, 1, 2, 3, 4, 55555555 (tlast) with m_data_tready=1 -> identical 7 words out in order; m_data_tlast only on 55555555; pkt_good_count=1; fill_level returns to 0.
REQ-030 Bad footer: send the same packet ending 55555554 (tlast) -> no output; pkt_drop_count=1; fill_level=0.
REQ-031 Early tlast: assert tlast on payload word 2, then send a good packet -> only the second packet is output, intact; drop=1, good=1.
REQ-032 Overflow: with m_data_tready=0, send 3 good packets (21 words into a 16-word buffer) -> good=2, drop=1, fill_level=14; then set m_data_tready=1 -> exactly 14 words out with two tlast pulses.
REQ-033 Junk and reset: send 12345678, 0000FFFF before a good packet -> junk ignored, drop=0, packet delivered; then pulse reset mid-output -> outputs go to 0 asynchronously, and after release m_data_tvalid=0 and counters=0.
